// File: rtl/seg_rx_display_if.sv
// Byte handshake from the UART receiver into the display block.
// One byte is transferred per single-cycle rx_valid strobe.
interface seg_rx_display_if;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/seg_rx_display.sv
// Eight-digit hex display fed by received bytes: newest digit on the right,
// backspace and line-end editing, and a multiplexed active-low scan output.
module seg_rx_display #(
  parameter int SCAN_DIV = 12500
) (
  input  logic                    clk,
  input  logic                    rst,
  seg_rx_display_if.slave         rx,
  output logic [7:0]              en,
  output logic [7:0]              seg_data,
  output logic [3:0]              char_cnt,
  output logic [7:0]              bad_cnt
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    K_HEX,
    K_BS,
    K_CLR,
    K_BAD
  } byte_kind_t;

  byte_kind_t    kind;
  logic [3:0]    nibble;
  logic [7:0]    blank;
  logic [3:0]    nib [8];
  logic [CW-1:0] scan_cnt;
  logic [2:0]    idx;
  logic [2:0]    idx_next;
  logic          wrap;
  logic [7:0]    seg_next;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 8'hC0;
      4'h1: hex_to_seg = 8'hF9;
      4'h2: hex_to_seg = 8'hA4;
      4'h3: hex_to_seg = 8'hB0;
      4'h4: hex_to_seg = 8'h99;
      4'h5: hex_to_seg = 8'h92;
      4'h6: hex_to_seg = 8'h82;
      4'h7: hex_to_seg = 8'hF8;
      4'h8: hex_to_seg = 8'h80;
      4'h9: hex_to_seg = 8'h90;
      4'hA: hex_to_seg = 8'h88;
      4'hB: hex_to_seg = 8'h83;
      4'hC: hex_to_seg = 8'hC6;
      4'hD: hex_to_seg = 8'hA1;
      4'hE: hex_to_seg = 8'h86;
      default: hex_to_seg = 8'h8E;
    endcase
  endfunction

  always_comb begin
    kind   = K_BAD;
    nibble = '0;
    if (rx.rx_data >= 8'h30 && rx.rx_data <= 8'h39) begin
      kind   = K_HEX;
      nibble = rx.rx_data[3:0];
    end else if ((rx.rx_data >= 8'h41 && rx.rx_data <= 8'h46) ||
                 (rx.rx_data >= 8'h61 && rx.rx_data <= 8'h66)) begin
      kind   = K_HEX;
      nibble = rx.rx_data[3:0] + 4'd9;
    end else if (rx.rx_data == 8'h08) begin
      kind = K_BS;
    end else if (rx.rx_data == 8'h0D || rx.rx_data == 8'h0A) begin
      kind = K_CLR;
    end
  end

  // Digit store: entry 0 is the newest character, entry 7 the oldest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank    <= '1;
      char_cnt <= '0;
      bad_cnt  <= '0;
      for (int unsigned i = 0; i < 8; i++) nib[i] <= '0;
    end else if (rx.rx_valid) begin
      case (kind)
        K_HEX: begin
          for (int unsigned i = 1; i < 8; i++) nib[i] <= nib[i-1];
          nib[0] <= nibble;
          blank  <= {blank[6:0], 1'b0};
          if (char_cnt != 4'd8) char_cnt <= char_cnt + 4'd1;
        end
        K_BS: begin
          if (char_cnt != 4'd0) begin
            for (int unsigned i = 0; i < 7; i++) nib[i] <= nib[i+1];
            nib[7]   <= '0;
            blank    <= {1'b1, blank[7:1]};
            char_cnt <= char_cnt - 4'd1;
          end
        end
        K_CLR: begin
          blank    <= '1;
          char_cnt <= '0;
        end
        default: begin
          if (bad_cnt != 8'hFF) bad_cnt <= bad_cnt + 8'd1;
        end
      endcase
    end
  end

  assign wrap     = (scan_cnt == CW'(SCAN_DIV - 1));
  assign idx_next = wrap ? idx + 3'd1 : idx;

  always_comb begin
    seg_next = 8'hFF;
    if (!blank[idx_next]) seg_next = hex_to_seg(nib[idx_next]);
  end

  // Outputs track the index being entered this edge, so en and seg_data
  // switch together on a wrap and seg_data follows store edits every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      en       <= 8'hFE;
      seg_data <= 8'hFF;
    end else begin
      scan_cnt <= wrap ? '0 : scan_cnt + 1'b1;
      idx      <= idx_next;
      en       <= ~(8'b1 << idx_next);
      seg_data <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_rx_display.sv
// Directed bench for seg_rx_display with a short scan period so that every
// digit can be observed through the multiplexed outputs.
module tb_seg_rx_display;

  logic       clk;
  logic       rst;
  logic [7:0] en;
  logic [7:0] seg_data;
  logic [3:0] char_cnt;
  logic [7:0] bad_cnt;

  int asserts;
  int failures;

  seg_rx_display_if rx_if ();

  seg_rx_display #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx_if.slave),
    .en       (en),
    .seg_data (seg_data),
    .char_cnt (char_cnt),
    .bad_cnt  (bad_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
    @(negedge clk);
    rx_if.rx_valid = 1'b0;
    @(negedge clk);
  endtask

  // Waits (bounded) until digit i is enabled and returns its segment pattern.
  task automatic get_seg(input int unsigned i, output logic [7:0] s, output bit ok);
    logic [7:0] want;
    want = ~(8'b1 << i);
    ok = 1'b0;
    s  = 'x;
    for (int n = 0; n < 48; n++) begin
      @(negedge clk);
      if (en === want) begin
        ok = 1'b1;
        s  = seg_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    asserts++;
    if (en !== 8'hFE || seg_data !== 8'hFF || char_cnt !== 4'd0 || bad_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset: en=%h seg=%h cnt=%0d bad=%0d, required en=fe seg=ff cnt=0 bad=0",
               en, seg_data, char_cnt, bad_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_three_chars();
    logic [7:0] exp [8];
    logic [7:0] s;
    bit ok;
    exp = '{8'h88, 8'hA4, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_reset();
    send_byte(8'h31);
    send_byte(8'h32);
    send_byte(8'h41);
    asserts++;
    if (char_cnt !== 4'd3) begin
      failures++;
      $display("FAIL three_cnt: got %0d, required 3", char_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      get_seg(i, s, ok);
      asserts++;
      if (!ok || s !== exp[i]) begin
        failures++;
        $display("FAIL three_seg%0d: got %h (seen=%0d), required %h", i, s, ok, exp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp [8];
    logic [7:0] s;
    bit ok;
    exp = '{8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4};
    do_reset();
    for (int c = 0; c < 10; c++) send_byte(8'h30 + 8'(c));
    asserts++;
    if (char_cnt !== 4'd8) begin
      failures++;
      $display("FAIL ovf_cnt: got %0d, required 8", char_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      get_seg(i, s, ok);
      asserts++;
      if (!ok || s !== exp[i]) begin
        failures++;
        $display("FAIL ovf_seg%0d: got %h (seen=%0d), required %h", i, s, ok, exp[i]);
      end
    end
  endtask

  task automatic test_backspace();
    logic [7:0] s;
    bit ok;
    do_reset();
    send_byte(8'h35);
    send_byte(8'h66);
    send_byte(8'h08);
    asserts++;
    if (char_cnt !== 4'd1) begin
      failures++;
      $display("FAIL bs1_cnt: got %0d, required 1", char_cnt);
    end
    get_seg(0, s, ok);
    asserts++;
    if (!ok || s !== 8'h92) begin
      failures++;
      $display("FAIL bs1_seg0: got %h (seen=%0d), required 92", s, ok);
    end
    get_seg(1, s, ok);
    asserts++;
    if (!ok || s !== 8'hFF) begin
      failures++;
      $display("FAIL bs1_seg1: got %h (seen=%0d), required ff", s, ok);
    end
    send_byte(8'h08);
    send_byte(8'h08);
    asserts++;
    if (char_cnt !== 4'd0) begin
      failures++;
      $display("FAIL bs3_cnt: got %0d, required 0", char_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      get_seg(i, s, ok);
      asserts++;
      if (!ok || s !== 8'hFF) begin
        failures++;
        $display("FAIL bs3_seg%0d: got %h (seen=%0d), required ff", i, s, ok);
      end
    end
  endtask

  task automatic test_bad_bytes();
    logic [7:0] s;
    bit ok;
    do_reset();
    send_byte(8'h33);
    send_byte(8'h47);
    send_byte(8'h20);
    asserts++;
    if (bad_cnt !== 8'd2) begin
      failures++;
      $display("FAIL bad_two: got %0d, required 2", bad_cnt);
    end
    for (int k = 0; k < 300; k++) send_byte(8'h7E);
    asserts++;
    if (bad_cnt !== 8'hFF || char_cnt !== 4'd1) begin
      failures++;
      $display("FAIL bad_sat: bad=%h cnt=%0d, required bad=ff cnt=1", bad_cnt, char_cnt);
    end
    get_seg(0, s, ok);
    asserts++;
    if (!ok || s !== 8'hB0) begin
      failures++;
      $display("FAIL bad_seg0: got %h (seen=%0d), required b0", s, ok);
    end
    send_byte(8'h0D);
    asserts++;
    if (char_cnt !== 4'd0 || bad_cnt !== 8'hFF) begin
      failures++;
      $display("FAIL cr_clear: cnt=%0d bad=%h, required cnt=0 bad=ff", char_cnt, bad_cnt);
    end
    get_seg(0, s, ok);
    asserts++;
    if (!ok || s !== 8'hFF) begin
      failures++;
      $display("FAIL cr_seg0: got %h (seen=%0d), required ff", s, ok);
    end
    send_byte(8'h46);
    send_byte(8'h63);
    send_byte(8'h0A);
    asserts++;
    if (char_cnt !== 4'd0) begin
      failures++;
      $display("FAIL lf_clear: got %0d, required 0", char_cnt);
    end
  endtask

  task automatic test_scan();
    logic [7:0] want;
    logic [7:0] s;
    bit ok;
    do_reset();
    for (int k = 0; k < 36; k++) begin
      want = ~(8'b1 << ((k / 4) % 8));
      asserts++;
      if (en !== want) begin
        failures++;
        $display("FAIL scan_en k=%0d: got %h, required %h", k, en, want);
      end
      // The edge following k=7 is a scan wrap; the byte must still land.
      if (k == 7) begin
        rx_if.rx_data  = 8'h37;
        rx_if.rx_valid = 1'b1;
      end else begin
        rx_if.rx_valid = 1'b0;
      end
      @(negedge clk);
    end
    asserts++;
    if (char_cnt !== 4'd1) begin
      failures++;
      $display("FAIL wrap_rx_cnt: got %0d, required 1", char_cnt);
    end
    get_seg(0, s, ok);
    asserts++;
    if (!ok || s !== 8'hF8) begin
      failures++;
      $display("FAIL wrap_rx_seg0: got %h (seen=%0d), required f8", s, ok);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 1; c <= 5; c++) send_byte(8'h30 + 8'(c));
    repeat (6) @(negedge clk);
    asserts++;
    if (char_cnt !== 4'd5) begin
      failures++;
      $display("FAIL arst_pre: got %0d, required 5", char_cnt);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    asserts++;
    if (en !== 8'hFE || seg_data !== 8'hFF || char_cnt !== 4'd0 || bad_cnt !== 8'd0) begin
      failures++;
      $display("FAIL arst: en=%h seg=%h cnt=%0d bad=%0d, required en=fe seg=ff cnt=0 bad=0",
               en, seg_data, char_cnt, bad_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    asserts  = 0;
    failures = 0;
    rst = 1'b1;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'h00;
    test_reset();
    test_three_chars();
    test_overflow();
    test_backspace();
    test_bad_bytes();
    test_scan();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/seg_rx_display.md
SEG_RX_DISPLAY -- requirements
Module: seg_rx_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 12500, clk cycles per digit slot (100 MHz -> 8 kHz slot rate, 1 kHz frame rate).
REQ-002 SHALL have port clk  input  1  system clock, 100 MHz; the block's only clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rx_data  input  8  received byte from the UART receiver, qualified by rx_valid.
REQ-005 SHALL have port rx_valid  input  1  single-cycle strobe, clk domain; one byte per assertion.
REQ-006 SHALL have port en  output  8  digit enables, active-low, one-hot-low.
REQ-007 SHALL have port seg_data  output  8  segments, active-low; bit7 = dp, bits6:0 = g..a.
REQ-008 SHALL have port char_cnt  output  4  number of valid digits held, 0..8.
REQ-009 SHALL have port bad_cnt  output  8  count of ignored bytes, saturating.

Function
REQ-010 SHALL hold an 8-entry digit store; each entry = {blank flag, 4-bit nibble}; entry 0 = newest, entry 7 = oldest.
REQ-011 SHALL treat bytes 8'h30-8'h39, 8'h41-8'h46, 8'h61-8'h66 as hex digits, nibble = value 0..F.
REQ-012 SHALL, on a hex digit, shift entry i to i+1 (entry 7 discarded), load entry 0 = {0, nibble}, char_cnt = min(char_cnt+1, 8); update visible the cycle after rx_valid.
REQ-013 SHALL, on 8'h08 (backspace) with char_cnt>0, shift entry i+1 to i, set entry 7 blank, decrement char_cnt; with char_cnt=0, no change.
REQ-014 SHALL, on 8'h0D or 8'h0A, set all entries blank and char_cnt = 0.
REQ-015 SHALL, on any other byte, leave the store unchanged and increment bad_cnt, holding at 8'hFF.
REQ-016 SHALL run a scan counter 0..SCAN_DIV-1; on wrap, digit index advances 0..7, 7 wraps to 0.
REQ-017 SHALL register en and seg_data; both change in the cycle after the scan counter wraps and reflect the new index; en = ~(8'b1 << index).
REQ-018 SHALL drive seg_data for digit index i from entry i: nibble 0..F -> C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E (hex); blank -> FF.
REQ-019 SHALL refresh seg_data from the store every cycle, so a store update reaches the active digit within 2 cycles without waiting for a scan wrap.
REQ-020 SHALL process rx_valid and scan advance independently when they coincide in the same cycle; neither is lost or delayed.
REQ-021 SHALL keep dp (bit7) off (1) in all cases.

Reset
REQ-022 SHALL, while rst=1, force all entries blank, char_cnt=0, bad_cnt=0, scan counter=0, index=0, en=8'hFE, seg_data=8'hFF.
REQ-023 SHALL, on rst asserted mid-scan or mid-update, return to the REQ-022 state immediately with no partial store writes.
REQ-024 SHALL resume scanning from index 0 at the first clk edge after rst deasserts, with the first wrap after SCAN_DIV cycles.

Verification
REQ-025 SHALL test: reset, then bytes "1","2","A" -> char_cnt=3; index0 seg=86? no: entry0='A' -> seg 88, entry1='2' -> A4, entry2='1' -> F9, entries 3-7 -> FF.
REQ-026 SHALL test: 10 bytes "0123456789" -> char_cnt=8; entry0 '9'=90, entry7 '2'=A4; '0','1' discarded.
REQ-027 SHALL test: "5","f", then 8'h08 -> char_cnt=1, entry0 '5'=92; second and third 8'h08 -> char_cnt=0, all FF.
REQ-028 SHALL test: bytes 8'h47, 8'h20, then 300 bytes of 8'h7E -> store unchanged, bad_cnt=8'hFF (saturated); then 8'h0D -> all blank, bad_cnt held.
REQ-029 SHALL test with SCAN_DIV=4: en sequence FE,FD,FB,F7,EF,DF,BF,7F,FE, each held 4 cycles; an rx_valid on a wrap cycle is applied.
REQ-030 SHALL test: rst pulse while char_cnt=5 mid-scan -> en=FE, seg=FF, char_cnt=0 asynchronously, without waiting for a clk edge.
